clk_reset_gen: RTL

//  Parametrised 8085-style clock and reset generator. It runs on the x1 crystal clock and

---
 rtl/clk_reset_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/clk_reset_gen.sv
// ---------------------------------------------------------------------------
// clk_reset_gen
// 8085-style two-phase clock and reset generator running on the x1 crystal.
// Produces non-overlapping phi1/phi2 and a 50% clk_out, all as registered
// levels derived from a phase counter. resetn_in is synchronised on
// deassertion into 'reset', and 'reset_out' is stretched for a programmable
// number of complete phase periods. Supports stop/resume and a software
// re-reset that re-runs the stretch sequence.
// ---------------------------------------------------------------------------
module clk_reset_gen #(
  parameter int PERIOD      = 4,  // x1 cycles per phase period (even, >= 4)
  parameter int PH_HIGH     = 1,  // x1 cycles each phase is high
  parameter int SYNC_STAGES = 2,  // deassertion synchroniser depth
  parameter int RST_STRETCH = 3   // phase periods reset_out outlasts reset
) (
  input  logic x1,
  input  logic resetn_in,
  input  logic stop_req,
  input  logic sw_rst,
  output logic phi1,
  output logic phi2,
  output logic clk_out,
  output logic reset,
  output logic reset_out,
  output logic stopped
);

  // -------------------------------------------------------------------------
  // Parameter legality
  // -------------------------------------------------------------------------
  if (PERIOD < 4 || (PERIOD % 2) != 0) begin : g_bad_period
    $error("clk_reset_gen: PERIOD must be even and >= 4 (got %0d)", PERIOD);
  end
  if (PH_HIGH < 1 || PH_HIGH > (PERIOD / 2 - 1)) begin : g_bad_ph_high
    $error("clk_reset_gen: PH_HIGH must be in [1, PERIOD/2-1] (got %0d)", PH_HIGH);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clk_reset_gen: SYNC_STAGES must be >= 2 (got %0d)", SYNC_STAGES);
  end
  if (RST_STRETCH < 1) begin : g_bad_stretch
    $error("clk_reset_gen: RST_STRETCH must be >= 1 (got %0d)", RST_STRETCH);
  end

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int CW = $clog2(PERIOD);
  localparam int SW = $clog2(RST_STRETCH + 1);

  localparam logic [CW-1:0] C_ZERO    = '0;
  localparam logic [CW-1:0] C_LAST    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_HALF    = CW'(PERIOD / 2);
  localparam logic [CW-1:0] C_PH_HIGH = CW'(PH_HIGH);
  localparam logic [CW-1:0] C_PH2_END = CW'(PERIOD / 2 + PH_HIGH);

  localparam logic [SW-1:0] C_STR_LOAD = SW'(RST_STRETCH);
  localparam logic [SW-1:0] C_STR_ONE  = SW'(1);

  localparam logic [2:0] S_RST      = 3'd0;
  localparam logic [2:0] S_STRETCH  = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_STOPPING = 3'd3;
  localparam logic [2:0] S_STOPPED  = 3'd4;

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [SW-1:0]          r_str;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] w_str_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_wrap;
  logic          w_sync_done;
  logic          w_active;

  // The chain is complete on the edge where a 1 enters its last stage.
  assign w_sync_done = r_sync[SYNC_STAGES-2];
  assign w_wrap      = (r_cnt == C_LAST);
  assign w_cnt_inc   = w_wrap ? C_ZERO : (r_cnt + 1'b1);

  // Deassertion synchroniser: shifts 1s in once resetn_in is released.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block ordering.
  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Next-state, next-count and stretch-counter logic.
  // NOTE: every output of this block is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_str_nxt   = r_str;
    unique case (r_state)
      S_RST: begin
        w_cnt_nxt = C_ZERO;
        if (w_sync_done) begin
          w_state_nxt = S_STRETCH;
          w_str_nxt   = C_STR_LOAD;
        end
      end
      S_STRETCH: begin
        if (sw_rst) begin
          w_str_nxt = C_STR_LOAD;
        end else if (w_wrap) begin
          if (r_str == C_STR_ONE) begin
            w_state_nxt = S_RUN;
          end
          w_str_nxt = r_str - 1'b1;
        end
      end
      S_RUN: begin
        if (sw_rst) begin
          w_state_nxt = S_STRETCH;
          w_str_nxt   = C_STR_LOAD;
        end else if (stop_req) begin
          w_state_nxt = S_STOPPING;
        end
      end
      S_STOPPING: begin
        if (sw_rst) begin
          w_state_nxt = S_STRETCH;
          w_str_nxt   = C_STR_LOAD;
        end else if (w_wrap) begin
          w_state_nxt = S_STOPPED;
        end
      end
      S_STOPPED: begin
        // Resuming or re-resetting both restart the period at cnt=0.
        w_cnt_nxt = C_ZERO;
        if (sw_rst) begin
          w_state_nxt = S_STRETCH;
          w_str_nxt   = C_STR_LOAD;
        end else if (!stop_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RST;
        w_cnt_nxt   = C_ZERO;
      end
    endcase
  end

  // Phases toggle only in states where the counter is running.
  assign w_active = (w_state_nxt == S_STRETCH) || (w_state_nxt == S_RUN) ||
                    (w_state_nxt == S_STOPPING);

  // FSM, phase counter and stretch counter registers.
  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      r_state <= S_RST;
      r_cnt   <= C_ZERO;
      r_str   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_str   <= w_str_nxt;
    end
  end

  // Outputs are decoded from the next count/state so they are registered
  // yet line up with r_cnt in the same cycle.
  always_ff @(posedge x1 or negedge resetn_in) begin
    if (!resetn_in) begin
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      clk_out   <= 1'b0;
      reset     <= 1'b1;
      reset_out <= 1'b1;
      stopped   <= 1'b0;
    end else begin
      phi1      <= w_active && (w_cnt_nxt < C_PH_HIGH);
      phi2      <= w_active && (w_cnt_nxt >= C_HALF) && (w_cnt_nxt < C_PH2_END);
      clk_out   <= w_active && (w_cnt_nxt < C_HALF);
      reset     <= ~w_sync_done;
      reset_out <= (w_state_nxt == S_RST) || (w_state_nxt == S_STRETCH);
      stopped   <= (w_state_nxt == S_STOPPED);
    end
  end

endmodule
